// File: rtl/reset_release_sequencer_if.sv
// Reset-release sequencer bundle: reset-source indications in, per-domain
// resets and sequencer status out. The master side drives the sources; the
// slave side is the sequencer itself.
interface reset_release_sequencer_if #(
  parameter int NUM_STAGES = 3
);
  logic                  ninit_done;
  logic                  fpga_reset_n;
  logic                  h2f_reset;
  logic                  emif_cal_success;
  logic [NUM_STAGES-1:0] stage_reset_n;
  logic [1:0]            seq_state;
  logic                  cal_timeout;
  logic [7:0]            reset_count;

  modport master (
    output ninit_done, fpga_reset_n, h2f_reset, emif_cal_success,
    input  stage_reset_n, seq_state, cal_timeout, reset_count
  );

  modport slave (
    input  ninit_done, fpga_reset_n, h2f_reset, emif_cal_success,
    output stage_reset_n, seq_state, cal_timeout, reset_count
  );
endinterface

// File: rtl/reset_release_sequencer.sv
// Holds all fabric reset domains until every reset source is clean and EMIF
// calibration is done, then releases the domains one at a time with a fixed
// gap. Any later fault drops every domain back into reset on the next edge.
module reset_release_sequencer #(
  parameter int NUM_STAGES    = 3,
  parameter int HOLD_MIN      = 16,
  parameter int STAGE_DELAY   = 1000,
  parameter int DELAY_WIDTH   = 16,
  parameter int CAL_TIMEOUT   = 10000000,
  parameter int TIMEOUT_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  reset_release_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_ASSERT   = 2'd0,
    ST_WAIT_CAL = 2'd1,
    ST_RELEASE  = 2'd2,
    ST_RUN      = 2'd3
  } state_t;

  localparam logic [DELAY_WIDTH-1:0]   HOLD_LAST  = DELAY_WIDTH'(HOLD_MIN - 1);
  localparam logic [DELAY_WIDTH-1:0]   STAGE_LAST = DELAY_WIDTH'(STAGE_DELAY - 1);
  localparam logic [DELAY_WIDTH-1:0]   DCNT_ONE   = DELAY_WIDTH'(1);
  localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST   = TIMEOUT_WIDTH'(CAL_TIMEOUT - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] TCNT_ONE   = TIMEOUT_WIDTH'(1);
  localparam logic [NUM_STAGES-1:0]    STAGE_ONE  = NUM_STAGES'(1);
  localparam logic [NUM_STAGES-1:0]    STAGE_ALL  = {NUM_STAGES{1'b1}};

  // Saturating re-entry counter step; never wraps past 255.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t                     r_state;
  logic [DELAY_WIDTH-1:0]     r_hold_cnt;
  logic [DELAY_WIDTH-1:0]     r_stage_cnt;
  logic [TIMEOUT_WIDTH-1:0]   r_tmo_cnt;
  logic [NUM_STAGES-1:0]      r_stage;
  logic                       r_cal_timeout;
  logic [7:0]                 r_reset_count;

  state_t                     w_state_nxt;
  logic [DELAY_WIDTH-1:0]     w_hold_nxt;
  logic [DELAY_WIDTH-1:0]     w_stage_cnt_nxt;
  logic [TIMEOUT_WIDTH-1:0]   w_tmo_nxt;
  logic [NUM_STAGES-1:0]      w_stage_nxt;
  logic                       w_cal_timeout_nxt;
  logic [7:0]                 w_reset_count_nxt;

  logic                       w_src_active;
  logic                       w_fault;
  logic [NUM_STAGES-1:0]      w_stage_shift;

  assign w_src_active  = bus.ninit_done | ~bus.fpga_reset_n | bus.h2f_reset;
  // Released bits form a thermometer code, so the next release is a shift-in of 1.
  assign w_stage_shift = (r_stage << 1) | STAGE_ONE;
  // Calibration loss only counts as a fault once a domain has been released.
  assign w_fault = ((r_state == ST_WAIT_CAL) & w_src_active) |
                   (((r_state == ST_RELEASE) | (r_state == ST_RUN)) &
                    (w_src_active | ~bus.emif_cal_success));

  // Next-state and next-register computation for the sequencer.
  always_comb begin
    w_state_nxt       = r_state;
    w_hold_nxt        = r_hold_cnt;
    w_stage_cnt_nxt   = r_stage_cnt;
    w_tmo_nxt         = r_tmo_cnt;
    w_stage_nxt       = r_stage;
    w_cal_timeout_nxt = r_cal_timeout;
    w_reset_count_nxt = r_reset_count;
    if (w_fault) begin
      w_state_nxt       = ST_ASSERT;
      w_stage_nxt       = '0;
      w_hold_nxt        = '0;
      w_reset_count_nxt = sat_inc(r_reset_count);
    end else begin
      case (r_state)
        ST_ASSERT: begin
          w_stage_nxt = '0;
          if (w_src_active) begin
            w_hold_nxt = '0;
          end else if (r_hold_cnt == HOLD_LAST) begin
            w_state_nxt = ST_WAIT_CAL;
            w_hold_nxt  = '0;
            w_tmo_nxt   = '0;
          end else begin
            w_hold_nxt = r_hold_cnt + DCNT_ONE;
          end
        end
        ST_WAIT_CAL: begin
          // Success is checked before timeout so it wins a same-edge tie.
          if (bus.emif_cal_success) begin
            w_stage_nxt     = STAGE_ONE;
            w_stage_cnt_nxt = '0;
            w_state_nxt     = (STAGE_ONE == STAGE_ALL) ? ST_RUN : ST_RELEASE;
          end else if (r_tmo_cnt == TMO_LAST) begin
            w_state_nxt       = ST_ASSERT;
            w_hold_nxt        = '0;
            w_cal_timeout_nxt = 1'b1;
            w_reset_count_nxt = sat_inc(r_reset_count);
          end else begin
            w_tmo_nxt = r_tmo_cnt + TCNT_ONE;
          end
        end
        ST_RELEASE: begin
          if (r_stage_cnt == STAGE_LAST) begin
            w_stage_nxt     = w_stage_shift;
            w_stage_cnt_nxt = '0;
            if (w_stage_shift == STAGE_ALL) begin
              w_state_nxt = ST_RUN;
            end else begin
              w_state_nxt = ST_RELEASE;
            end
          end else begin
            w_stage_cnt_nxt = r_stage_cnt + DCNT_ONE;
          end
        end
        ST_RUN: begin
          w_stage_nxt = STAGE_ALL;
        end
        default: begin
          w_state_nxt = ST_ASSERT;
          w_stage_nxt = '0;
          w_hold_nxt  = '0;
        end
      endcase
    end
  end

  // State and counter registers; synchronous reset dominates all inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_ASSERT;
      r_hold_cnt    <= '0;
      r_stage_cnt   <= '0;
      r_tmo_cnt     <= '0;
      r_stage       <= '0;
      r_cal_timeout <= 1'b0;
      r_reset_count <= 8'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_hold_cnt    <= w_hold_nxt;
      r_stage_cnt   <= w_stage_cnt_nxt;
      r_tmo_cnt     <= w_tmo_nxt;
      r_stage       <= w_stage_nxt;
      r_cal_timeout <= w_cal_timeout_nxt;
      r_reset_count <= w_reset_count_nxt;
    end
  end

  assign bus.stage_reset_n = r_stage;
  assign bus.seq_state     = r_state;
  assign bus.cal_timeout   = r_cal_timeout;
  assign bus.reset_count   = r_reset_count;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Bench for reset_release_sequencer: directed scenarios plus a random phase,
// all checked every cycle against a behavioural model, with literal
// expectations at key points that pin both the DUT and the model.
module tb_reset_release_sequencer;

  localparam int NS   = 3;
  localparam int HOLD = 4;
  localparam int SD   = 8;
  localparam int CALT = 20;

  logic clk;
  logic reset;

  reset_release_sequencer_if #(.NUM_STAGES(NS)) bus_if ();

  reset_release_sequencer #(
    .NUM_STAGES(NS), .HOLD_MIN(HOLD), .STAGE_DELAY(SD),
    .DELAY_WIDTH(16), .CAL_TIMEOUT(CALT), .TIMEOUT_WIDTH(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus_if.slave)
  );

  int n_vec;
  int n_bad;
  int n_print;

  // Model: phase uses the externally visible seq_state numbering.
  int m_phase;
  int m_rel;
  int m_clean;
  int m_wait;
  int m_since;
  int m_tmo;
  int m_cnt;
  bit m_live;
  bit m_src;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // Behavioural model, advanced on each rising edge from the sampled inputs.
  always @(posedge clk) begin
    m_live = 1'b1;
    m_src  = bus_if.ninit_done | ~bus_if.fpga_reset_n | bus_if.h2f_reset;
    if (reset) begin
      m_phase = 0; m_rel = 0; m_clean = 0; m_wait = 0;
      m_since = 0; m_tmo = 0; m_cnt = 0;
    end else if ((m_phase == 1 && m_src) ||
                 (m_phase >= 2 && (m_src || !bus_if.emif_cal_success))) begin
      m_phase = 0; m_rel = 0; m_clean = 0; m_cnt = sat(m_cnt);
    end else if (m_phase == 0) begin
      if (m_src) m_clean = 0;
      else if (m_clean + 1 == HOLD) begin
        m_phase = 1; m_clean = 0; m_wait = 0;
      end else m_clean = m_clean + 1;
    end else if (m_phase == 1) begin
      if (bus_if.emif_cal_success) begin
        m_rel = 1; m_since = 0; m_phase = (NS == 1) ? 3 : 2;
      end else if (m_wait + 1 == CALT) begin
        m_phase = 0; m_clean = 0; m_tmo = 1; m_cnt = sat(m_cnt);
      end else m_wait = m_wait + 1;
    end else if (m_phase == 2) begin
      if (m_since + 1 == SD) begin
        m_rel = m_rel + 1; m_since = 0;
        if (m_rel == NS) m_phase = 3;
      end else m_since = m_since + 1;
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    if (m_live) begin
      n_vec = n_vec + 1;
      if (int'(bus_if.stage_reset_n) != ((1 << m_rel) - 1) ||
          int'(bus_if.seq_state) != m_phase ||
          int'(bus_if.cal_timeout) != m_tmo ||
          int'(bus_if.reset_count) != m_cnt) begin
        n_bad = n_bad + 1;
        if (n_print < 40) begin
          n_print = n_print + 1;
          $display("FAIL cycle_model t=%0t got stage=%b state=%0d tmo=%0d cnt=%0d want stage=%0d state=%0d tmo=%0d cnt=%0d",
                   $time, bus_if.stage_reset_n, bus_if.seq_state, bus_if.cal_timeout,
                   bus_if.reset_count, (1 << m_rel) - 1, m_phase, m_tmo, m_cnt);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int dut_v, input int mod_v, input int exp_v);
    n_vec = n_vec + 1;
    if (dut_v != exp_v || mod_v != exp_v) begin
      n_bad = n_bad + 1;
      $display("FAIL %s got dut=%0d model=%0d want %0d", name, dut_v, mod_v, exp_v);
    end
  endtask

  task automatic chk_all(input string name, input int st, input int ph, input int tmo, input int cnt);
    chk({name, "_stage"}, int'(bus_if.stage_reset_n), (1 << m_rel) - 1, st);
    chk({name, "_state"}, int'(bus_if.seq_state), m_phase, ph);
    chk({name, "_caltmo"}, int'(bus_if.cal_timeout), m_tmo, tmo);
    chk({name, "_rstcnt"}, int'(bus_if.reset_count), m_cnt, cnt);
  endtask

  initial begin
    n_vec = 0; n_bad = 0; n_print = 0; m_live = 1'b0;
    m_phase = 0; m_rel = 0; m_clean = 0; m_wait = 0;
    m_since = 0; m_tmo = 0; m_cnt = 0; m_src = 1'b0;
    reset = 1'b1;
    bus_if.ninit_done = 1'b1;
    bus_if.fpga_reset_n = 1'b1;
    bus_if.h2f_reset = 1'b0;
    bus_if.emif_cal_success = 1'b1;

    // Power-up
    tick(2);
    chk_all("reset", 0, 0, 0, 0);
    reset = 1'b0;
    tick(10);
    bus_if.ninit_done = 1'b0;
    tick(3);  chk("pu_hold3_state", int'(bus_if.seq_state), m_phase, 0);
    tick(1);  chk("pu_waitcal_state", int'(bus_if.seq_state), m_phase, 1);
    tick(1);  chk_all("pu_stage0", 1, 2, 0, 0);
    tick(7);  chk("pu_gap_stage", int'(bus_if.stage_reset_n), (1 << m_rel) - 1, 1);
    tick(1);  chk("pu_stage1", int'(bus_if.stage_reset_n), (1 << m_rel) - 1, 3);
    tick(8);  chk_all("pu_run", 7, 3, 0, 0);

    // Sync reset in RUN
    reset = 1'b1;
    tick(1);  chk_all("srst_run", 0, 0, 0, 0);
    reset = 1'b0;

    // Calibration timeout
    bus_if.emif_cal_success = 1'b0;
    tick(4);  chk("tmo_wait_state", int'(bus_if.seq_state), m_phase, 1);
    tick(19); chk_all("tmo_pre", 0, 1, 0, 0);
    tick(1);  chk_all("tmo_hit", 0, 0, 1, 1);
    bus_if.emif_cal_success = 1'b1;
    tick(5);  chk_all("tmo_retry_s0", 1, 2, 1, 1);
    tick(16); chk_all("tmo_retry_run", 7, 3, 1, 1);

    // HPS warm reset pulse
    bus_if.h2f_reset = 1'b1;
    tick(1);  chk_all("warm_drop", 0, 0, 1, 2);
    bus_if.h2f_reset = 1'b0;
    tick(4);  chk("warm_wait_state", int'(bus_if.seq_state), m_phase, 1);
    tick(17); chk_all("warm_run", 7, 3, 1, 2);

    // Hold glitch
    bus_if.h2f_reset = 1'b1;
    tick(1);
    bus_if.h2f_reset = 1'b0;
    tick(3);
    bus_if.fpga_reset_n = 1'b0;
    tick(1);
    bus_if.fpga_reset_n = 1'b1;
    tick(3);  chk_all("glitch_hold", 0, 0, 1, 3);
    tick(1);  chk("glitch_wait_state", int'(bus_if.seq_state), m_phase, 1);

    // Mid-release abort
    tick(1);  chk("abort_s0", int'(bus_if.stage_reset_n), (1 << m_rel) - 1, 1);
    tick(8);  chk("abort_s1", int'(bus_if.stage_reset_n), (1 << m_rel) - 1, 3);
    tick(3);
    bus_if.emif_cal_success = 1'b0;
    tick(1);  chk_all("abort_drop", 0, 0, 1, 4);
    tick(10); chk("abort_no_s2", int'(bus_if.stage_reset_n), (1 << m_rel) - 1, 0);

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 399) == 0);
      bus_if.ninit_done = ($urandom_range(0, 149) == 0);
      bus_if.fpga_reset_n = ($urandom_range(0, 149) != 0);
      bus_if.h2f_reset = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 99) == 0)
        bus_if.emif_cal_success = ~bus_if.emif_cal_success;
      tick(1);
    end

    // Saturation
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    bus_if.ninit_done = 1'b0;
    bus_if.fpga_reset_n = 1'b1;
    bus_if.h2f_reset = 1'b0;
    bus_if.emif_cal_success = 1'b1;
    tick(30);
    chk_all("sat_start", 7, 3, 0, 0);
    for (int p = 0; p < 300; p++) begin
      bus_if.h2f_reset = 1'b1;
      tick(1);
      bus_if.h2f_reset = 1'b0;
      tick(25);
    end
    chk_all("sat_255", 7, 3, 0, 255);
    bus_if.h2f_reset = 1'b1;
    tick(1);
    bus_if.h2f_reset = 1'b0;
    chk_all("sat_hold", 0, 0, 0, 255);
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
